// File: rtl/peridot_csr_spi_slave.sv
// Avalon-MM CSR SPI slave: oversampled SCLK/SS_n/MOSI, one TX holding byte, one RX byte.
// Optional sticky overrun flag built when PERIDOT_SPIS_OVERRUN_EN is defined.
`timescale 1ns/1ps
module peridot_csr_spi_slave #(
    parameter int unsigned DEFAULT_REG_BITRVS    = 0,
    parameter int unsigned DEFAULT_REG_MODE      = 0,
    parameter logic [7:0]  DEFAULT_UNDERRUN_DATA = 8'hFF
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic        avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        ins_irq,
    input  logic        spi_ss_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // [0] metastable stage, [1] synchronised, [2] delayed copy for edge detection
    logic [2:0] ss_q, sclk_q;
    logic [1:0] mosi_q;

    state_e     state_q, state_d;
    logic [2:0] bitcount_q, bitcount_d;
    logic [7:0] rxshift_q, rxshift_d;
    logic [7:0] txshift_q, txshift_d;
    logic [7:0] rxdata_q, rxdata_d;
    logic [7:0] holding_q, holding_d;
    logic       rxready_q, rxready_d;
    logic       txempty_q, txempty_d;
    logic       irqena_q, irqena_d;
    logic       bitrvs_q, bitrvs_d;
    logic [1:0] mode_q, mode_d;
    logic       miso_q;

    logic selected, sclk_rise, sclk_fall, sample_edge, shift_edge;
    logic wr0, wr1, load, complete, overrun;

    assign selected    = ~ss_q[1];
    assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
    assign sample_edge = (mode_q[1] == mode_q[0]) ? sclk_rise : sclk_fall;
    assign shift_edge  = (mode_q[1] == mode_q[0]) ? sclk_fall : sclk_rise;
    assign wr0         = avs_write & ~avs_address;
    assign wr1         = avs_write & avs_address;

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            ss_q       <= 3'b111;
            sclk_q     <= 3'b000;
            mosi_q     <= 2'b00;
            state_q    <= StIdle;
            bitcount_q <= 3'd0;
            rxshift_q  <= 8'h00;
            txshift_q  <= 8'hFF;
            rxdata_q   <= 8'h00;
            holding_q  <= 8'h00;
            rxready_q  <= 1'b0;
            txempty_q  <= 1'b1;
            irqena_q   <= 1'b0;
            bitrvs_q   <= DEFAULT_REG_BITRVS[0];
            mode_q     <= DEFAULT_REG_MODE[1:0];
            miso_q     <= 1'b1;
        end else begin
            ss_q       <= {ss_q[1:0], spi_ss_n};
            sclk_q     <= {sclk_q[1:0], spi_sclk};
            mosi_q     <= {mosi_q[0], spi_mosi};
            state_q    <= state_d;
            bitcount_q <= bitcount_d;
            rxshift_q  <= rxshift_d;
            txshift_q  <= txshift_d;
            rxdata_q   <= rxdata_d;
            holding_q  <= holding_d;
            rxready_q  <= rxready_d;
            txempty_q  <= txempty_d;
            irqena_q   <= irqena_d;
            bitrvs_q   <= bitrvs_d;
            mode_q     <= mode_d;
            miso_q     <= txshift_q[7];
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcount_d = bitcount_q;
        rxshift_d  = rxshift_q;
        txshift_d  = txshift_q;
        rxdata_d   = rxdata_q;
        holding_d  = holding_q;
        rxready_d  = rxready_q;
        txempty_d  = txempty_q;
        irqena_d   = irqena_q;
        bitrvs_d   = bitrvs_q;
        mode_d     = mode_q;
        load       = 1'b0;
        complete   = 1'b0;

        case (state_q)
            StIdle: begin
                if (selected) begin
                    state_d    = StActive;
                    bitcount_d = 3'd0;
                    load       = ~mode_q[0];
                end
            end
            StActive: begin
                if (!selected) begin
                    state_d    = StIdle;
                    bitcount_d = 3'd0;
                end else if (sample_edge) begin
                    rxshift_d  = {rxshift_q[6:0], mosi_q[1]};
                    bitcount_d = bitcount_q + 3'd1;
                    complete   = (bitcount_q == 3'd7);
                end else if (shift_edge) begin
                    if (bitcount_q == 3'd0) load = 1'b1;
                    else txshift_d = {txshift_q[6:0], 1'b1};
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            txshift_d = txempty_q ? DEFAULT_UNDERRUN_DATA : holding_q;
            txempty_d = 1'b1;
        end
        if (complete) rxdata_d = {rxshift_q[6:0], mosi_q[1]};

        // Host write is evaluated after the load so a same-cycle refill leaves txempty=0
        if (wr0) begin
            irqena_d = avs_writedata[15];
            if (avs_writedata[9]) rxready_d = 1'b0;
            if (avs_writedata[8]) begin
                holding_d = bitrvs_q ? rev8(avs_writedata[7:0]) : avs_writedata[7:0];
                txempty_d = 1'b0;
            end
        end
        if (complete) rxready_d = 1'b1;

        if (wr1 && !selected) begin
            bitrvs_d = avs_writedata[15];
            mode_d   = avs_writedata[13:12];
        end
    end

`ifdef PERIDOT_SPIS_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) overrun_q <= 1'b0;
        else overrun_q <= overrun_d;
    end

    always_comb begin
        overrun_d = overrun_q;
        if (wr0 && avs_writedata[10]) overrun_d = 1'b0;
        if (complete && rxready_q) overrun_d = 1'b1;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    always_comb begin
        avs_readdata = 32'h0;
        if (!avs_address) begin
            avs_readdata[15]  = irqena_q;
            avs_readdata[11]  = selected;
            avs_readdata[10]  = overrun;
            avs_readdata[9]   = rxready_q;
            avs_readdata[8]   = txempty_q;
            avs_readdata[7:0] = bitrvs_q ? rev8(rxdata_q) : rxdata_q;
        end else begin
            avs_readdata[15]    = bitrvs_q;
            avs_readdata[13:12] = mode_q;
        end
    end

    assign ins_irq     = irqena_q & (rxready_q | overrun);
    assign spi_miso    = miso_q;
    assign spi_miso_oe = selected;

    logic unused_bits;
    assign unused_bits = ^{avs_read, avs_writedata[31:16], avs_writedata[14],
                           avs_writedata[11], avs_writedata[10]};

endmodule

// File: tb/tb_peridot_csr_spi_slave.sv
// Bench for peridot_csr_spi_slave: transaction-level register/byte model plus directed SPI traffic.
`timescale 1ns/1ps
module tb_peridot_csr_spi_slave;

    localparam int H = 5;  // SCLK half period in csi_clk cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        avs_address = 1'b0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'h0;
    logic        ins_irq;
    logic        spi_ss_n = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;

    int checks = 0;
    int errors = 0;
    logic quiet = 1'b0;

    // Model of the programmer-visible state
    logic       m_irqena, m_rxready, m_overrun, m_txempty, m_bitrvs, m_selected;
    logic [7:0] m_rxdata, m_holding, cur_tx;
    logic [1:0] m_mode;

    always #5 clk = ~clk;

    peridot_csr_spi_slave #(
        .DEFAULT_REG_BITRVS   (0),
        .DEFAULT_REG_MODE     (0),
        .DEFAULT_UNDERRUN_DATA(8'hFF)
    ) dut (
        .csi_clk      (clk),
        .rsi_reset_n  (rst_n),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .ins_irq      (ins_irq),
        .spi_ss_n     (spi_ss_n),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        r = {<<{v}};
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic a);
        logic [31:0] r;
        r = 32'h0;
        if (!a) begin
            r[15]  = m_irqena;
            r[11]  = m_selected;
            r[10]  = m_overrun;
            r[9]   = m_rxready;
            r[8]   = m_txempty;
            r[7:0] = m_bitrvs ? rev8(m_rxdata) : m_rxdata;
        end else begin
            r[15]    = m_bitrvs;
            r[13:12] = m_mode;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_irqena = 0; m_rxready = 0; m_overrun = 0; m_txempty = 1;
        m_bitrvs = 0; m_mode = 2'd0; m_selected = 0; m_rxdata = 8'h00; m_holding = 8'h00;
    endtask

    task automatic do_load(output logic [7:0] v);
        v = m_txempty ? 8'hFF : m_holding;
        m_txempty = 1'b1;
    endtask

    // Continuous check of register view, interrupt and MISO enable while the model is settled
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (quiet && rst_n) begin
                chk("readdata", avs_readdata, exp_rd(avs_address));
                chk("ins_irq", {31'b0, ins_irq}, {31'b0, m_irqena & (m_rxready | m_overrun)});
                chk("miso_oe", {31'b0, spi_miso_oe}, {31'b0, m_selected});
            end
        end
    end

    task automatic host_write(input logic a, input logic [31:0] d);
        quiet = 0;
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1;
        @(negedge clk);
        avs_write = 0; avs_address = 0;
        if (!a) begin
            m_irqena = d[15];
            if (d[9]) m_rxready = 0;
`ifdef PERIDOT_SPIS_OVERRUN_EN
            if (d[10]) m_overrun = 0;
`endif
            if (d[8]) begin
                m_holding = m_bitrvs ? rev8(d[7:0]) : d[7:0];
                m_txempty = 0;
            end
        end else if (!m_selected) begin
            m_bitrvs = d[15];
            m_mode   = d[13:12];
        end
        quiet = 1;
    endtask

    task automatic host_read(input logic a, output logic [31:0] v);
        @(negedge clk);
        avs_address = a; avs_read = 1;
        #1 v = avs_readdata;
        @(negedge clk);
        avs_read = 0; avs_address = 0;
    endtask

    task automatic set_mode(input logic bitrvs, input logic [1:0] mode);
        host_write(1'b1, {16'h0, bitrvs, 1'b0, mode, 12'h0});
        quiet = 0;
        spi_sclk = mode[1];
        repeat (4) @(negedge clk);
        quiet = 1;
    endtask

    task automatic ss_assert();
        quiet = 0;
        spi_ss_n = 0;
        repeat (2 * H) @(negedge clk);
        m_selected = 1;
        if (!m_mode[0]) do_load(cur_tx);
        quiet = 1;
    endtask

    task automatic ss_release();
        quiet = 0;
        spi_ss_n = 1;
        repeat (H) @(negedge clk);
        m_selected = 0;
        quiet = 1;
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] got);
        logic cpol, cpha;
        quiet = 0;
        cpol = m_mode[1];
        cpha = m_mode[0];
        got = 8'h00;
        if (cpha) do_load(cur_tx);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                spi_mosi = mo[7-i];
                repeat (H) @(negedge clk);
                spi_sclk = ~cpol;
                got = {got[6:0], spi_miso};
                repeat (H) @(negedge clk);
                spi_sclk = cpol;
            end else begin
                spi_sclk = ~cpol;
                spi_mosi = mo[7-i];
                repeat (H) @(negedge clk);
                spi_sclk = cpol;
                got = {got[6:0], spi_miso};
                repeat (H) @(negedge clk);
            end
        end
        repeat (H) @(negedge clk);
        if (nbits == 8) begin
            chk("miso_byte", {24'h0, got}, {24'h0, cur_tx});
`ifdef PERIDOT_SPIS_OVERRUN_EN
            if (m_rxready) m_overrun = 1;
`endif
            m_rxready = 1;
            m_rxdata  = mo;
            // The trailing shift edge of a CPHA=0 byte loads the next one
            if (!cpha) do_load(cur_tx);
        end
        quiet = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0]  got;
        logic [31:0] rd;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        quiet = 1;

        // Reset state
        host_read(1'b0, rd);
        chk("rst_reg00", rd, 32'h0000_0100);
        host_read(1'b1, rd);
        chk("rst_reg01", rd, 32'h0000_0000);
        chk("rst_miso", {31'b0, spi_miso}, 32'd1);
        chk("rst_oe", {31'b0, spi_miso_oe}, 32'd0);
        chk("rst_irq", {31'b0, ins_irq}, 32'd0);

        // Mode 0 single byte
        host_write(1'b0, 32'h0000_013C);
        ss_assert();
        xfer(8'hA5, 8, got);
        chk("m0_miso_lit", {24'h0, got}, 32'h3C);
        ss_release();
        host_read(1'b0, rd);
        chk("m0_reg00_lit", rd, 32'h0000_03A5);
        host_write(1'b0, 32'h0000_0600);

        // Modes 3 and 1, two bytes with a refill between them
        for (int m = 0; m < 2; m++) begin
            set_mode(1'b0, (m == 0) ? 2'd3 : 2'd1);
            host_write(1'b0, 32'h0000_0181);
            ss_assert();
            host_read(1'b0, rd);
            chk("cpha1_no_ss_load", {31'b0, rd[8]}, 32'd0);
            xfer(8'h81, 8, got);
            chk("cpha1_b0_lit", {24'h0, got}, 32'h81);
            host_write(1'b0, 32'h0000_017E);
            xfer(8'h7E, 8, got);
            chk("cpha1_b1_lit", {24'h0, got}, 32'h7E);
            ss_release();
            host_read(1'b0, rd);
            chk("cpha1_rx_lit", {24'h0, rd[7:0]}, 32'h7E);
            host_write(1'b0, 32'h0000_0600);
        end

        // Mode 2 underrun, then bit-reversed traffic
        set_mode(1'b0, 2'd2);
        ss_assert();
        xfer(8'h00, 8, got);
        chk("underrun_lit", {24'h0, got}, 32'hFF);
        ss_release();
        host_write(1'b0, 32'h0000_0600);
        set_mode(1'b1, 2'd2);
        host_write(1'b0, 32'h0000_0101);
        ss_assert();
        xfer(8'h12, 8, got);
        chk("bitrvs_tx_lit", {24'h0, got}, 32'h80);
        host_read(1'b0, rd);
        chk("bitrvs_rx_lit", rd, 32'h0000_0B48);
        ss_release();
        host_write(1'b0, 32'h0000_0600);

        // Interrupt and overrun
        set_mode(1'b0, 2'd0);
        host_write(1'b0, 32'h0000_8000);
        ss_assert();
        xfer(8'h11, 8, got);
        xfer(8'h22, 8, got);
        ss_release();
        host_read(1'b0, rd);
`ifdef PERIDOT_SPIS_OVERRUN_EN
        chk("overrun_lit", rd, 32'h0000_8722);
`else
        chk("overrun_lit", rd, 32'h0000_8322);
`endif
        chk("irq_set_lit", {31'b0, ins_irq}, 32'd1);
        host_write(1'b0, 32'h0000_8600);
        chk("irq_clr_lit", {31'b0, ins_irq}, 32'd0);

        // Aborted partial byte, locked reg01 while selected
        ss_assert();
        xfer(8'hF0, 5, got);
        ss_release();
        host_read(1'b0, rd);
        chk("partial_no_rx", {31'b0, rd[9]}, 32'd0);
        ss_assert();
        host_write(1'b1, 32'h0000_B000);
        xfer(8'h55, 8, got);
        ss_release();
        host_read(1'b0, rd);
        chk("after_partial_rx", {24'h0, rd[7:0]}, 32'h55);
        host_read(1'b1, rd);
        chk("reg01_locked", rd, 32'h0000_0000);

        // Reset pulse mid-byte
        ss_assert();
        xfer(8'hC3, 3, got);
        quiet = 0;
        @(negedge clk);
        rst_n = 0;
        @(posedge clk);
        #1;
        chk("midrst_reg00", avs_readdata, 32'h0000_0100);
        chk("midrst_oe", {31'b0, spi_miso_oe}, 32'd0);
        chk("midrst_miso", {31'b0, spi_miso}, 32'd1);
        chk("midrst_irq", {31'b0, ins_irq}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        spi_ss_n = 1;
        spi_sclk = 0;
        model_reset();
        repeat (5) @(negedge clk);
        quiet = 1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
